// File: rtl/multi_reg_addr_seq.sv
// Multi-register load/store address sequencer: expands one LA/SA/LM/SM request into per-register memory beats.
// First beat one cycle after start; one beat per unstalled cycle; stall freezes the current beat and all state.
module multi_reg_addr_seq #(
    parameter int AW   = 16,
    parameter int NREG = 8,
    parameter int IW   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [NREG-1:0] mask,
    input  logic [AW-1:0]   base,
    input  logic            stall,
    output logic            busy,
    output logic            beat_valid,
    output logic            beat_we,
    output logic [AW-1:0]   beat_addr,
    output logic [IW-1:0]   beat_reg,
    output logic            beat_last,
    output logic            done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREG-1:0] pend_q, pend_d;

    logic [IW-1:0]   cur_reg;
    logic [NREG-1:0] cur_sel;
    logic            one_left;
    logic            run;
    logic [NREG-1:0] start_pend;

    // Register i lives at mask bit NREG-1-i, so the lowest register is the highest set bit.
    always_comb begin
        cur_reg = '0;
        cur_sel = '0;
        for (int j = 0; j < NREG; j++) begin
            if (pend_q[j]) begin
                cur_reg    = IW'(NREG - 1 - j);
                cur_sel    = '0;
                cur_sel[j] = 1'b1;
            end
        end
        one_left = (pend_q != '0) && ((pend_q & (pend_q - NREG'(1))) == '0);
    end

    // Whole-bank ops (LA/SA) ignore the caller's mask.
    assign start_pend = op[1] ? mask : '1;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    we_d    = op[0];
                    base_d  = base;
                    cnt_d   = '0;
                    pend_d  = start_pend;
                    state_d = (start_pend != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    pend_d = pend_q & ~cur_sel;
                    cnt_d  = cnt_q + AW'(1);
                    if (one_left) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            base_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        run        = (state_q == S_RUN);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        beat_valid = run;
        beat_we    = run & we_q;
        beat_addr  = run ? (base_q + cnt_q) : '0;
        beat_reg   = run ? cur_reg : '0;
        beat_last  = run & one_left;
    end

endmodule

// File: tb/tb_multi_reg_addr_seq.sv
// Randomised bench for multi_reg_addr_seq against a beat-list reference model built from op/mask/base.
module tb_multi_reg_addr_seq;

    localparam int AW   = 16;
    localparam int NREG = 8;
    localparam int IW   = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [1:0]      op;
    logic [NREG-1:0] mask;
    logic [AW-1:0]   base;
    logic            stall;
    logic            busy;
    logic            beat_valid;
    logic            beat_we;
    logic [AW-1:0]   beat_addr;
    logic [IW-1:0]   beat_reg;
    logic            beat_last;
    logic            done;

    int n_checks = 0;
    int n_errors = 0;

    multi_reg_addr_seq #(.AW(AW), .NREG(NREG), .IW(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op         (op),
        .mask       (mask),
        .base       (base),
        .stall      (stall),
        .busy       (busy),
        .beat_valid (beat_valid),
        .beat_we    (beat_we),
        .beat_addr  (beat_addr),
        .beat_reg   (beat_reg),
        .beat_last  (beat_last),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic v, input logic we, input logic [AW-1:0] a,
                              input int r, input logic last, input logic bz, input logic dn);
        check_eq({tag, ".valid"}, 32'(beat_valid), 32'(v));
        check_eq({tag, ".we"},    32'(beat_we),    32'(we));
        check_eq({tag, ".addr"},  32'(beat_addr),  32'(a));
        check_eq({tag, ".reg"},   32'(beat_reg),   32'(r));
        check_eq({tag, ".last"},  32'(beat_last),  32'(last));
        check_eq({tag, ".busy"},  32'(busy),       32'(bz));
        check_eq({tag, ".done"},  32'(done),       32'(dn));
    endtask

    // Issue one transfer and walk its expected beat list. stall_at/stall_n force a stall burst on
    // one beat; rst_at (>=0) asserts reset while that beat is presented and abandons the transfer.
    task automatic run_xfer(input logic [1:0] o, input logic [NREG-1:0] m, input logic [AW-1:0] b,
                            input int rate, input int stall_at, input int stall_n, input int rst_at);
        int regs[$];
        logic [NREG-1:0] pend;
        logic [AW-1:0] exp_addr;
        int k;
        int held;
        int seen;
        pend = o[1] ? m : '1;
        for (int i = 0; i < NREG; i++) begin
            if (pend[NREG-1-i]) regs.push_back(i);
        end
        check_eq("idle.busy", 32'(busy), 32'd0);
        start = 1'b1; op = o; mask = m; base = b; stall = 1'b0;
        tick();
        start = 1'b0;
        k = 0; held = 0; seen = 0;
        while (k < regs.size()) begin
            exp_addr = b + AW'(k);
            check_outs("beat", 1'b1, o[0], exp_addr, regs[k], (k == regs.size() - 1), 1'b1, 1'b0);
            if (k == rst_at) begin
                rst_n = 1'b0; start = 1'b1; stall = 1'b1;
                tick();
                check_outs("rst", 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
                rst_n = 1'b1; start = 1'b0; stall = 1'b0;
                return;
            end
            if (k == stall_at) seen++;
            if (k == stall_at && held < stall_n) begin
                stall = 1'b1;
                held++;
            end else begin
                stall = ($urandom_range(0, 99) < rate);
            end
            start = 1'($urandom_range(0, 1));
            op    = 2'($urandom);
            mask  = NREG'($urandom);
            base  = AW'($urandom);
            tick();
            if (!stall) k++;
        end
        stall = 1'b0;
        if (rate == 0 && stall_at >= 0 && stall_at < regs.size())
            check_eq("hold_cycles", 32'(seen), 32'(stall_n + 1));
        check_outs("done", 1'b0, 1'b0, '0, 0, 1'b0, 1'b1, 1'b1);
        start = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        check_outs("idle", 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; op = 2'b00; mask = '0; base = 16'h1234; stall = 1'b1;
        repeat (3) tick();
        check_outs("reset", 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1; start = 1'b0; stall = 1'b0;
        tick();
        check_outs("post_reset", 1'b0, 1'b0, '0, 0, 1'b0, 1'b0, 1'b0);

        run_xfer(2'b00, 8'h00, 16'h0100, 0, -1, 0, -1);       // LA full bank
        run_xfer(2'b11, 8'b1010_0101, 16'h0200, 0, -1, 0, -1); // SM sparse mask
        run_xfer(2'b10, 8'h00, 16'h0300, 0, -1, 0, -1);       // LM empty mask
        run_xfer(2'b00, 8'h00, 16'hFFFE, 0, 1, 3, -1);        // wrap + stall burst on beat 2
        run_xfer(2'b01, 8'h00, 16'h0400, 0, -1, 0, 2);        // SA reset on beat 3
        run_xfer(2'b01, 8'h00, 16'h0500, 0, -1, 0, -1);       // start right after release

        for (int t = 0; t < 40; t++) begin
            run_xfer(2'($urandom), NREG'($urandom), AW'($urandom), 30,
                     $urandom_range(0, 7), $urandom_range(0, 3), -1);
        end
        run_xfer(2'b11, 8'h01, 16'hFFFF, 0, -1, 0, -1);       // single beat, last on first
        run_xfer(2'b10, 8'h80, 16'h0000, 50, 0, 2, -1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_reg_addr_seq.md
MULTI_REG_ADDR_SEQ -- requirements
Module: multi_reg_addr_seq

Interface
REQ-001 The block SHALL have parameter AW, default 16, meaning address/data width in bits.
REQ-002 The block SHALL have parameter NREG, default 8, meaning number of registers covered by one multi-transfer (2..16).
REQ-003 The block SHALL have parameter IW, default 3, meaning register-index width, with 2^IW >= NREG.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-006 Port start, input, 1 bit: request to begin a multi-transfer; honoured only in IDLE.
REQ-007 Port op, input, 2 bits: 00 LA, 01 SA, 10 LM, 11 SM; sampled with start.
REQ-008 Port mask, input, NREG bits: register select; bit NREG-1-i selects register i; sampled with start.
REQ-009 Port base, input, AW bits: start address from execute stage; sampled with start.
REQ-010 Port stall, input, 1 bit: memory/pipeline stall; holds the current beat.
REQ-011 Port busy, output, 1 bit: high in RUN and DONE states.
REQ-012 Port beat_valid, output, 1 bit: current beat outputs are valid.
REQ-013 Port beat_we, output, 1 bit: beat is a store (SA/SM).
REQ-014 Port beat_addr, output, AW bits: memory address of current beat.
REQ-015 Port beat_reg, output, IW bits: register index of current beat.
REQ-016 Port beat_last, output, 1 bit: current beat is the final beat.
REQ-017 Port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-018 FSM SHALL have states IDLE, RUN and DONE, held in registers.
REQ-019 IDLE with start=1 at edge t: latch op, base, and pending mask; go to RUN if pending mask is non-zero, else go to DONE.
REQ-020 For LA/SA the pending mask SHALL be forced to all ones, ignoring input mask.
REQ-021 In RUN, beat_valid=1; beat_reg SHALL be the lowest index i whose pending bit NREG-1-i is set.
REQ-022 beat_addr SHALL be base + beat count, where beat count is the number of beats already accepted; sum taken modulo 2^AW (wraps, no error).
REQ-023 A beat SHALL be accepted on an edge where beat_valid=1 and stall=0; the accepted bit is cleared and beat count increments.
REQ-024 Skipped (zero) mask bits SHALL consume no cycle and no address.
REQ-025 beat_last SHALL be 1 when exactly one pending bit remains.
REQ-026 While stall=1, all beat outputs and internal state SHALL hold unchanged.
REQ-027 Acceptance of the last beat SHALL move the FSM to DONE; DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-028 First beat SHALL be valid in the cycle after start is accepted; an unstalled N-beat transfer occupies N RUN cycles plus one DONE cycle.
REQ-029 start in RUN or DONE SHALL be ignored, with no state or output effect.
REQ-030 Outside RUN, beat_valid, beat_we, beat_last SHALL be 0; beat_addr and beat_reg SHALL be 0.
REQ-031 beat_we SHALL equal op[0] in RUN.

Reset
REQ-032 rst_n=0 at an edge SHALL force IDLE, clear pending mask, beat count, and latched op/base, and drive every output to 0, overriding start and stall.
REQ-033 Reset mid-transfer SHALL abandon the transfer with no done pulse; a start in the first cycle after reset release SHALL be honoured.

Verification
REQ-034 LA, base=0x0100, NREG=8, no stall -> 8 beats, reg 0..7, addr 0x0100..0x0107, beat_we=0, beat_last on beat 8, done one cycle after beat 8.
REQ-035 SM, mask=8'b1010_0101, base=0x0200 -> 4 beats: reg 0/0x0200, reg 2/0x0201, reg 5/0x0202, reg 7/0x0203; beat_we=1.
REQ-036 LM, mask=0 -> no beat_valid, busy for one cycle, done pulse the cycle after start.
REQ-037 LA, base=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000, ... 0x0005; also stall=1 for 3 cycles on beat 2 -> beat 2 outputs held for 4 cycles, no beat lost or duplicated.
REQ-038 Reset asserted on beat 3 of SA -> next cycle IDLE with all outputs 0 and no done; start after release runs normally; start during RUN ignored.
